inst_issue: RTL and testbench

INST_ISSUE -- requirements
Module: inst_issue

---
 rtl/inst_issue.sv | 128 ++++++++++++
 tb/tb_inst_issue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/inst_issue.sv
// inst_issue: program-buffer instruction issuer.
// A DEPTH x INST_W buffer is loaded while idle. A start request then streams
// len opcodes onto the registered inst output, one per un-stalled cycle.
// While idle or stalled, inst carries NOP.
// Optional feature macro: INST_ISSUE_LOOP_EN. It adds the loops input and
// replays the program loops+1 times back-to-back.
module inst_issue #(
  parameter int DEPTH  = 16,
  parameter int INST_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [INST_W-1:0]          wr_data,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     len,
`ifdef INST_ISSUE_LOOP_EN
  input  logic [3:0]                 loops,
`endif
  input  logic                       stall,
  output logic [INST_W-1:0]          inst,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [INST_W-1:0] NOP = '0;
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nx;
  logic [INST_W-1:0] buffer [DEPTH];
  logic [AW-1:0]     ptr;
  logic [AW:0]       pass_cnt;
  logic [AW:0]       len_q;
  logic              more_passes;
  logic              last_issue;
`ifdef INST_ISSUE_LOOP_EN
  logic [3:0]        loop_cnt;
`endif

  assign busy = (state == RUN);

  // Program buffer: writable only while idle, never cleared by reset
  always_ff @(posedge clk) begin
    if (wr_en && !busy) buffer[wr_addr] <= wr_data;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: leave RUN on the edge that issues the final instruction
  always_comb begin
    state_nx    = state;
    more_passes = 1'b0;
    last_issue  = 1'b0;
`ifdef INST_ISSUE_LOOP_EN
    more_passes = (loop_cnt != '0);
`endif
    case (state)
      IDLE: if (start && len != '0) state_nx = RUN;
      RUN: begin
        last_issue = !stall && (pass_cnt == CNT_ONE) && !more_passes;
        if (last_issue) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Issue datapath: pointer, counters, registered inst and done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst     <= NOP;
      done     <= 1'b0;
      ptr      <= '0;
      pass_cnt <= '0;
      len_q    <= '0;
`ifdef INST_ISSUE_LOOP_EN
      loop_cnt <= '0;
`endif
    end else begin
      inst <= NOP;
      done <= 1'b0;
      case (state)
        IDLE: begin
          ptr <= '0;
          if (start) begin
            // len=0 completes immediately with a done pulse and no issue
            if (len == '0) done <= 1'b1;
            pass_cnt <= len;
            len_q    <= len;
`ifdef INST_ISSUE_LOOP_EN
            loop_cnt <= loops;
`endif
          end
        end
        RUN: begin
          if (!stall) begin
            inst <= buffer[ptr];
            if (pass_cnt == CNT_ONE) begin
              // End of a pass: either rewind for the next pass with no gap, or finish
              if (more_passes) begin
`ifdef INST_ISSUE_LOOP_EN
                loop_cnt <= loop_cnt - 1'b1;
`endif
                pass_cnt <= len_q;
                ptr      <= '0;
              end else begin
                pass_cnt <= '0;
                done     <= 1'b1;
              end
            end else begin
              pass_cnt <= pass_cnt - 1'b1;
              ptr      <= ptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_issue.sv
// Directed testbench for inst_issue; expected values are hand-derived opcodes.
module tb_inst_issue;

  localparam int DEPTH  = 16;
  localparam int INST_W = 8;

  localparam logic [7:0] NOP   = 8'h00;
  localparam logic [7:0] MEM1  = 8'h11;
  localparam logic [7:0] MEM2  = 8'h12;
  localparam logic [7:0] ADD   = 8'h21;
  localparam logic [7:0] MULT  = 8'h22;
  localparam logic [7:0] WRITE = 8'h30;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        start;
  logic [4:0]  len;
  logic        stall;
  logic [7:0]  inst;
  logic        busy;
  logic        done;
`ifdef INST_ISSUE_LOOP_EN
  logic [3:0]  loops;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] prog [5];

  inst_issue #(.DEPTH(DEPTH), .INST_W(INST_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .len     (len),
`ifdef INST_ISSUE_LOOP_EN
    .loops   (loops),
`endif
    .stall   (stall),
    .inst    (inst),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one sampled edge; after return the DUT is in RUN (len>0)
  task automatic do_start(input logic [4:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  initial begin
    prog[0] = MEM1; prog[1] = MEM2; prog[2] = ADD; prog[3] = MULT; prog[4] = WRITE;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; len = '0; stall = 1'b0;
`ifdef INST_ISSUE_LOOP_EN
    loops = '0;
`endif
    #1;
    check("rst_inst", inst, NOP);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    tick();
    reset = 1'b0;
    tick();

    // Load the five-instruction program
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = prog[i];
      tick();
    end
    wr_en = 1'b0;

    // Basic run: five opcodes back-to-back, done with busy dropping
    do_start(5'd5);
    check("run_busy0", busy, 1);
    check("run_nop0", inst, NOP);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("run_inst%0d", i), inst, prog[i]);
      check($sformatf("run_done%0d", i), done, (i == 4) ? 1 : 0);
      check($sformatf("run_busy%0d", i), busy, (i == 4) ? 0 : 1);
    end
    tick();
    check("run_after_inst", inst, NOP);
    check("run_after_done", done, 0);

    // Stall two cycles after ADD issues
    do_start(5'd5);
    tick(); check("st_mem1", inst, MEM1);
    tick(); check("st_mem2", inst, MEM2);
    tick(); check("st_add", inst, ADD);
    stall = 1'b1;
    tick(); check("st_nop1", inst, NOP); check("st_busy1", busy, 1);
    tick(); check("st_nop2", inst, NOP); check("st_done_early", done, 0);
    stall = 1'b0;
    tick(); check("st_mult", inst, MULT); check("st_done_mult", done, 0);
    tick(); check("st_write", inst, WRITE); check("st_done", done, 1);
    tick(); check("st_done_clear", done, 0);

    // len=0: no issue, done on the next cycle
    start = 1'b1; len = 5'd0;
    tick();
    start = 1'b0;
    check("z_inst", inst, NOP);
    check("z_busy", busy, 0);
    check("z_done", done, 1);
    tick();
    check("z_done_clear", done, 0);
    check("z_busy2", busy, 0);

    // Write and start during RUN are ignored
    do_start(5'd5);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'hEE;
    start = 1'b1; len = 5'd2;
    tick(); check("wb_mem1", inst, MEM1);
    wr_en = 1'b0; start = 1'b0;
    tick(); check("wb_mem2", inst, MEM2);
    tick(); check("wb_add", inst, ADD); check("wb_done_early", done, 0);
    tick(); check("wb_mult", inst, MULT);
    tick(); check("wb_write", inst, WRITE); check("wb_done", done, 1);
    tick(); check("wb_idle_busy", busy, 0); check("wb_idle_inst", inst, NOP);

    // Reset on the cycle MULT would issue
    do_start(5'd5);
    tick(); check("rr_mem1", inst, MEM1);
    tick(); check("rr_mem2", inst, MEM2);
    tick(); check("rr_add", inst, ADD);
    reset = 1'b1;
    #1;
    check("rr_inst", inst, NOP);
    check("rr_busy", busy, 0);
    check("rr_done", done, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rr_nodone%0d", i), done, 0);
      check($sformatf("rr_noinst%0d", i), inst, NOP);
    end
    do_start(5'd5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rr_re%0d", i), inst, prog[i]);
    end
    check("rr_re_done", done, 1);
    tick();

`ifdef INST_ISSUE_LOOP_EN
    // Looped program: len=2 of MEM1, three passes, single done
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = MEM1;
    tick();
    wr_en = 1'b0;
    loops = 4'd2;
    do_start(5'd2);
    loops = 4'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("lp_inst%0d", i), inst, MEM1);
      check($sformatf("lp_done%0d", i), done, (i == 5) ? 1 : 0);
    end
    tick();
    check("lp_after_inst", inst, NOP);
    check("lp_after_done", done, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
